// File: rtl/z_window_accumulator_if.sv
// Control and result bus of the Z window accumulator: window start/abort
// towards the block, registered count with valid/ready handshake back out.
interface z_window_accumulator_if #(
    parameter int CNT_W = 8,
    parameter int WIN_W = 8
);
    logic             START;
    logic             ABORT;
    logic [WIN_W-1:0] WIN_LEN;
    logic             OUT_READY;
    logic [CNT_W-1:0] CNT_OUT;
    logic             CNT_VALID;
    logic             OVF;
    logic             BUSY;

    modport master (
        output START, ABORT, WIN_LEN, OUT_READY,
        input  CNT_OUT, CNT_VALID, OVF, BUSY
    );

    modport slave (
        input  START, ABORT, WIN_LEN, OUT_READY,
        output CNT_OUT, CNT_VALID, OVF, BUSY
    );
endinterface

// File: rtl/z_window_accumulator.sv
// Counts Z pulses over a programmable number of P_0-enabled cycles and
// offers the saturating count downstream through a valid/ready handshake.
module z_window_accumulator #(
    parameter int CNT_W = 8,
    parameter int WIN_W = 8
) (
    input  logic                  CK,
    input  logic                  RST,
    input  logic                  Z,
    input  logic                  P_0,
    z_window_accumulator_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] ACC_MAX = '1;

    state_t           r_state;
    logic [CNT_W-1:0] r_acc;
    logic [WIN_W-1:0] r_win;
    logic [CNT_W-1:0] r_cnt_out;
    logic             r_valid;
    logic             r_ovf;
    logic             r_busy;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_acc_nxt;
    logic [WIN_W-1:0] w_win_nxt;
    logic [CNT_W-1:0] w_cnt_out_nxt;
    logic             w_ovf_nxt;
    logic             w_start_ok;
    logic             w_sat_hit;
    logic [CNT_W-1:0] w_acc_inc;

    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the case infers a latch.
        w_state_nxt   = r_state;
        w_acc_nxt     = r_acc;
        w_win_nxt     = r_win;
        w_cnt_out_nxt = r_cnt_out;
        w_ovf_nxt     = r_ovf;

        w_start_ok = bus.START && (bus.WIN_LEN != '0);
        w_sat_hit  = Z && (r_acc == ACC_MAX);
        w_acc_inc  = (Z && !w_sat_hit) ? r_acc + CNT_W'(1) : r_acc;

        case (r_state)
            S_IDLE: begin
                if (w_start_ok) begin
                    w_state_nxt = S_RUN;
                    w_win_nxt   = bus.WIN_LEN;
                    w_acc_nxt   = '0;
                    w_ovf_nxt   = 1'b0;
                end
            end
            S_RUN: begin
                if (bus.ABORT) begin
                    w_state_nxt = S_IDLE;
                end else if (P_0) begin
                    w_acc_nxt = w_acc_inc;
                    w_ovf_nxt = r_ovf | w_sat_hit;
                    w_win_nxt = r_win - WIN_W'(1);
                    // The last enabled edge's Z is part of the published count.
                    if (r_win == WIN_W'(1)) begin
                        w_cnt_out_nxt = w_acc_inc;
                        w_state_nxt   = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (bus.OUT_READY) begin
                    if (w_start_ok) begin
                        w_state_nxt = S_RUN;
                        w_win_nxt   = bus.WIN_LEN;
                        w_acc_nxt   = '0;
                        w_ovf_nxt   = 1'b0;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            r_state   <= S_IDLE;
            r_acc     <= '0;
            r_win     <= '0;
            r_cnt_out <= '0;
            r_valid   <= 1'b0;
            r_ovf     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values of the others.
            r_state   <= w_state_nxt;
            r_acc     <= w_acc_nxt;
            r_win     <= w_win_nxt;
            r_cnt_out <= w_cnt_out_nxt;
            r_ovf     <= w_ovf_nxt;
            r_busy    <= (w_state_nxt == S_RUN);
            r_valid   <= (w_state_nxt == S_HOLD);
        end
    end

    assign bus.CNT_OUT   = r_cnt_out;
    assign bus.CNT_VALID = r_valid;
    assign bus.OVF       = r_ovf;
    assign bus.BUSY      = r_busy;

endmodule

// File: tb/tb_z_window_accumulator.sv
// Directed bench for z_window_accumulator: a window-level reference model is
// compared against the DUT every negedge, plus literal spot checks.
module tb_z_window_accumulator;

    localparam int CNT_W = 4;
    localparam int WIN_W = 8;
    localparam int MAX   = (1 << CNT_W) - 1;

    logic CK;
    logic RST;
    logic Z;
    logic P_0;

    int n_checks = 0;
    int n_errors = 0;

    z_window_accumulator_if #(.CNT_W(CNT_W), .WIN_W(WIN_W)) bus ();

    z_window_accumulator #(.CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
        .CK  (CK),
        .RST (RST),
        .Z   (Z),
        .P_0 (P_0),
        .bus (bus)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Window-level reference: remaining enabled cycles, running count, published result.
    bit m_busy, m_valid, m_ovf;
    int m_remaining, m_count, m_result;

    always @(posedge CK or posedge RST) begin
        if (RST) begin
            m_busy      <= 1'b0;
            m_valid     <= 1'b0;
            m_ovf       <= 1'b0;
            m_remaining <= 0;
            m_count     <= 0;
            m_result    <= 0;
        end else if (m_busy) begin
            if (bus.ABORT) begin
                m_busy <= 1'b0;
            end else if (P_0) begin
                if (Z && m_count == MAX) m_ovf <= 1'b1;
                if (Z && m_count < MAX) m_count <= m_count + 1;
                m_remaining <= m_remaining - 1;
                if (m_remaining == 1) begin
                    m_result <= (Z && m_count < MAX) ? m_count + 1 : m_count;
                    m_busy   <= 1'b0;
                    m_valid  <= 1'b1;
                end
            end
        end else if (!m_valid || bus.OUT_READY) begin
            m_valid <= 1'b0;
            if (bus.START && bus.WIN_LEN != 0) begin
                m_busy      <= 1'b1;
                m_remaining <= int'(bus.WIN_LEN);
                m_count     <= 0;
                m_ovf       <= 1'b0;
            end
        end
    end

    always @(negedge CK) begin
        check("cmp_busy",  32'(bus.BUSY),      32'(m_busy));
        check("cmp_valid", 32'(bus.CNT_VALID), 32'(m_valid));
        check("cmp_ovf",   32'(bus.OVF),       32'(m_ovf));
        check("cmp_cnt",   32'(bus.CNT_OUT),   32'(m_result));
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge CK);
            #1;
        end
    endtask

    task automatic start_window(input int len);
        bus.WIN_LEN = WIN_W'(len);
        bus.START   = 1'b1;
        tick();
        bus.START   = 1'b0;
    endtask

    task automatic handshake();
        bus.OUT_READY = 1'b1;
        tick();
        bus.OUT_READY = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  32'(bus.BUSY),      0);
        check({tag, "_valid"}, 32'(bus.CNT_VALID), 0);
        check({tag, "_ovf"},   32'(bus.OVF),       0);
        check({tag, "_cnt"},   32'(bus.CNT_OUT),   0);
    endtask

    initial begin
        logic [4:0] z_seq;
        logic [4:0] p_seq;

        RST = 1'b1;
        Z = 1'b0;
        P_0 = 1'b0;
        bus.START = 1'b0;
        bus.ABORT = 1'b0;
        bus.WIN_LEN = '0;
        bus.OUT_READY = 1'b0;
        tick(2);
        check_all_zero("reset");
        RST = 1'b0;
        tick();

        // Window of 4 with Z = 1,0,1,1
        P_0 = 1'b1;
        start_window(4);
        check("t1_busy_start", 32'(bus.BUSY), 1);
        z_seq = 5'b01101;
        for (int i = 0; i < 4; i++) begin
            Z = z_seq[i];
            tick();
        end
        Z = 1'b0;
        check("t1_busy_end", 32'(bus.BUSY), 0);
        check("t1_valid", 32'(bus.CNT_VALID), 1);
        check("t1_cnt", 32'(bus.CNT_OUT), 3);
        check("t1_ovf", 32'(bus.OVF), 0);
        tick(3);
        check("t1_held", 32'(bus.CNT_VALID), 1);
        handshake();
        check("t1_released", 32'(bus.CNT_VALID), 0);

        // Window of 3 with P_0 toggling, Z always high
        start_window(3);
        Z = 1'b1;
        p_seq = 5'b10101;
        for (int i = 0; i < 5; i++) begin
            P_0 = p_seq[i];
            tick();
        end
        Z = 1'b0;
        P_0 = 1'b1;
        check("t2_valid", 32'(bus.CNT_VALID), 1);
        check("t2_cnt", 32'(bus.CNT_OUT), 3);
        handshake();

        // Saturation: 20 pulses into a 4-bit accumulator
        start_window(20);
        Z = 1'b1;
        tick(20);
        Z = 1'b0;
        check("t3_cnt_sat", 32'(bus.CNT_OUT), 15);
        check("t3_ovf", 32'(bus.OVF), 1);
        handshake();
        check("t3_ovf_sticky_idle", 32'(bus.OVF), 1);
        start_window(2);
        check("t3_ovf_cleared", 32'(bus.OVF), 0);
        tick(2);
        check("t3b_cnt", 32'(bus.CNT_OUT), 0);
        check("t3b_ovf", 32'(bus.OVF), 0);
        handshake();

        // HOLD ignores Z; handshake with back-to-back start
        start_window(2);
        Z = 1'b1;
        tick(2);
        for (int i = 0; i < 10; i++) begin
            Z = i[0];
            tick();
        end
        check("t4_hold_cnt", 32'(bus.CNT_OUT), 2);
        check("t4_hold_valid", 32'(bus.CNT_VALID), 1);
        bus.OUT_READY = 1'b1;
        Z = 1'b0;
        start_window(2);
        bus.OUT_READY = 1'b0;
        check("t4_b2b_busy", 32'(bus.BUSY), 1);
        check("t4_b2b_valid", 32'(bus.CNT_VALID), 0);
        Z = 1'b1;
        tick();
        Z = 1'b0;
        tick();
        check("t4_second_valid", 32'(bus.CNT_VALID), 1);
        check("t4_second_cnt", 32'(bus.CNT_OUT), 1);
        handshake();

        // Abort at cycle 2 of a window of 8; zero-length start ignored
        start_window(8);
        Z = 1'b1;
        tick(2);
        bus.ABORT = 1'b1;
        tick();
        bus.ABORT = 1'b0;
        Z = 1'b0;
        check("t5_abort_busy", 32'(bus.BUSY), 0);
        check("t5_abort_valid", 32'(bus.CNT_VALID), 0);
        check("t5_abort_keep_cnt", 32'(bus.CNT_OUT), 1);
        tick(2);
        check("t5_no_result", 32'(bus.CNT_VALID), 0);
        start_window(0);
        check("t5_zero_len", 32'(bus.BUSY), 0);
        bus.ABORT = 1'b1;
        tick();
        bus.ABORT = 1'b0;

        // Asynchronous reset mid-RUN and in HOLD
        start_window(8);
        Z = 1'b1;
        tick(3);
        #2;
        RST = 1'b1;
        #1;
        check_all_zero("t6_rst_run");
        tick();
        RST = 1'b0;
        start_window(1);
        tick();
        check("t6_hold_valid", 32'(bus.CNT_VALID), 1);
        check("t6_hold_cnt", 32'(bus.CNT_OUT), 1);
        #2;
        RST = 1'b1;
        #1;
        check_all_zero("t6_rst_hold");
        tick();
        RST = 1'b0;
        start_window(3);
        tick(3);
        Z = 1'b0;
        check("t6_fresh_cnt", 32'(bus.CNT_OUT), 3);
        check("t6_fresh_valid", 32'(bus.CNT_VALID), 1);
        handshake();
        tick(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/z_window_accumulator.md
Name: z_window_accumulator

Overview:
- Downstream consumer of the 16-stage counter/comparator stage's serial output Z.
- Counts Z pulses over a programmable window of enabled clock cycles. The enabled cycles are those with P_0 high, the same enable that drives the upstream counter.
- Presents the window count through a valid/ready handshake to the next stage.
- Turns the upstream pulse stream into a measured pulse density per window.

Parameters:
- CNT_W, 8, width of the Z pulse accumulator and of the result.
- WIN_W, 8, width of the window-length field and of the window down-counter.

Ports:
- CK  input  1  clock; all state updates on the rising edge.
- RST  input  1  asynchronous active-high reset.
- Z  input  1  pulse stream from the upstream counter/comparator stage; sampled each CK edge.
- P_0  input  1  count enable; the same signal that drives the upstream stage. Only cycles with P_0=1 count toward the window.
- WIN_LEN  input  WIN_W  window length in enabled cycles; sampled only when a start is accepted.
- START  input  1  request to begin a window.
- ABORT  input  1  cancels a window in progress.
- OUT_READY  input  1  downstream ready.
- CNT_OUT  output  CNT_W  Z pulse count of the completed window.
- CNT_VALID  output  1  result available.
- OVF  output  1  accumulator saturated during this window.
- BUSY  output  1  window in progress (RUN state).

Behaviour:
- Reset: asynchronous, active-high; takes effect immediately.
  - State goes to IDLE.
  - CNT_OUT=0, CNT_VALID=0, OVF=0, BUSY=0.
  - Accumulator and window counter are cleared.
  - Reset mid-window discards all partial results.
- States: IDLE, RUN, HOLD. All outputs are registered.
- IDLE:
  - START=1 with WIN_LEN!=0: load window counter with WIN_LEN, clear accumulator and OVF, go to RUN on the next edge (BUSY=1 that cycle).
  - START with WIN_LEN=0: ignored; stay in IDLE.
- RUN, each edge with P_0=1:
  - If Z=1, accumulator increments by 1, saturating at 2^CNT_W-1.
  - An increment attempted while the accumulator is at max sets OVF (sticky for the window).
  - Window counter decrements by 1.
- RUN, P_0=0: accumulator and window counter hold; Z is ignored.
- Window end: the enabled edge at which the window counter equals 1.
  - That edge's Z is included in the count.
  - CNT_OUT takes the final count and CNT_VALID goes to 1; both are visible the cycle after that edge.
  - State goes to HOLD and BUSY goes to 0.
  - Latency from the last counted Z to CNT_VALID is 1 cycle.
- ABORT in RUN: on the next edge go to IDLE, BUSY=0, no result produced. CNT_OUT keeps its previous value and CNT_VALID stays 0. ABORT outside RUN is ignored.
- START while in RUN is ignored.
- HOLD:
  - CNT_OUT and OVF are stable and CNT_VALID=1 until CNT_VALID and OUT_READY are both high on an edge.
  - On handshake, if START=1 and WIN_LEN!=0 in the same cycle, go straight to RUN with a fresh window. CNT_VALID drops and BUSY rises on that edge, with no IDLE bubble.
  - On handshake otherwise, go to IDLE with CNT_VALID=0.
  - OVF clears only when a new window starts.
- OUT_READY is don't-care when CNT_VALID=0. The block never drops a result: Z and P_0 are ignored in HOLD.
- WIN_LEN=1: a one-enabled-cycle window, result equals that cycle's Z.
- Width rules:
  - Window counter is WIN_W bits.
  - Maximum window is 2^WIN_W-1 enabled cycles.
  - Accumulator never wraps.

Test Plan:
- Reset then WIN_LEN=4, START 1 cycle, P_0=1, Z=1,0,1,1 -> BUSY for 4 cycles, then CNT_VALID=1, CNT_OUT=3, OVF=0, held until OUT_READY=1. Then IDLE with CNT_VALID=0.
- WIN_LEN=3, P_0 toggles 1,0,1,0,1 with Z=1 every cycle -> only the 3 enabled cycles count. CNT_OUT=3, valid after the 5th cycle.
- CNT_W=4, WIN_LEN=20, Z=1 always, P_0=1 -> CNT_OUT=15, OVF=1. Next window (WIN_LEN=2, Z=0) -> CNT_OUT=0, OVF=0.
- HOLD with OUT_READY=0 for 10 cycles while Z pulses -> CNT_OUT unchanged. Then OUT_READY=1 and START=1 together with WIN_LEN=2 -> next edge BUSY=1, CNT_VALID=0; second result arrives 2 enabled cycles later.
- ABORT at cycle 2 of a WIN_LEN=8 window -> IDLE next edge, CNT_VALID stays 0. START with WIN_LEN=0 -> no state change.
- RST pulse asynchronously mid-RUN, and again in HOLD -> all outputs 0 immediately, state IDLE. A fresh window then counts from 0.
